// File: rtl/msrv32_pc_seq_ctrl_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and
// the instruction memory (slave).
interface msrv32_pc_seq_ctrl_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;

    modport master (output imem_req_out, output imem_addr_out, input imem_ready_in);
    modport slave  (input imem_req_out, input imem_addr_out, output imem_ready_in);
endinterface

// File: rtl/msrv32_pc_seq_ctrl.sv
// Fetch/PC sequencer: owns the PC, issues instruction fetches and applies
// trap/mret/branch redirects at fetch completion or while stalled.
module msrv32_pc_seq_ctrl #(
    parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
    parameter int          RESET_HOLD_CYC = 2
) (
    input  logic                         ms_riscv32_mp_clk_in,
    input  logic                         ms_riscv32_mp_rst_in,
    input  logic                         stall_in,
    input  logic                         branch_taken_in,
    input  logic [31:0]                  branch_target_in,
    input  logic                         trap_taken_in,
    input  logic [31:0]                  trap_vector_in,
    input  logic                         mret_in,
    input  logic [31:0]                  epc_in,
    msrv32_pc_seq_ctrl_if.master         imem,
    output logic [31:0]                  pc_out,
    output logic [31:0]                  pc_mux_out,
    output logic                         pc_load_out,
    output logic                         flush_out,
    output logic                         misaligned_out,
    output logic [1:0]                   state_out
);

    typedef enum logic [1:0] {HOLD = 2'd0, FETCH = 2'd1, WAIT = 2'd2, STALL = 2'd3} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYC - 1);

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt;
    logic [31:0] pc;
    // Pending redirect priority: 3 trap, 2 mret, 1 branch, 0 none.
    logic [1:0]  pend_prio, new_prio;
    logic [31:0] pend_tgt, new_tgt, eff_tgt, mux;
    logic        take_new, eff_valid, ack, apply, req, misaligned;

    always_comb begin
        new_prio   = 2'd0;
        new_tgt    = 32'h0;
        misaligned = 1'b0;
        if (state != HOLD) begin
            if (trap_taken_in) begin
                new_prio = 2'd3;
                new_tgt  = {trap_vector_in[31:2], 2'b00};
            end else if (mret_in) begin
                new_prio = 2'd2;
                new_tgt  = {epc_in[31:2], 2'b00};
            end else if (branch_taken_in) begin
                if (branch_target_in[1:0] != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    new_prio = 2'd1;
                    new_tgt  = branch_target_in;
                end
            end
        end
        take_new  = (new_prio != 2'd0) && (new_prio >= pend_prio);
        eff_valid = take_new || (pend_prio != 2'd0);
        eff_tgt   = take_new ? new_tgt : pend_tgt;
        mux       = eff_valid ? eff_tgt : pc + 32'd4;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        ack       = 1'b0;
        apply     = 1'b0;
        unique case (state)
            HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = FETCH;
            FETCH: begin
                // A redirect in flight keeps the fetch going so it can be applied at ack.
                if (stall_in && !eff_valid) begin
                    state_nxt = STALL;
                end else begin
                    req = 1'b1;
                    if (imem.imem_ready_in) ack = 1'b1;
                    else                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (imem.imem_ready_in) begin
                    ack       = 1'b1;
                    state_nxt = stall_in ? STALL : FETCH;
                end
            end
            STALL: begin
                if (eff_valid) apply = 1'b1;
                if (!stall_in) state_nxt = FETCH;
            end
            default: state_nxt = HOLD;
        endcase
        apply = apply | ack;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state     <= HOLD;
            hold_cnt  <= 4'd0;
            pc        <= BOOT_ADDR;
            pend_prio <= 2'd0;
            pend_tgt  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == HOLD) hold_cnt <= hold_cnt + 4'd1;
            if (apply) pc <= mux;
            if (apply) begin
                pend_prio <= 2'd0;
                pend_tgt  <= 32'h0;
            end else if (take_new) begin
                pend_prio <= new_prio;
                pend_tgt  <= new_tgt;
            end
        end
    end

    assign imem.imem_req_out  = req;
    assign imem.imem_addr_out = pc;
    assign pc_out             = pc;
    assign pc_mux_out         = (state == HOLD) ? 32'h0 : mux;
    assign pc_load_out        = apply;
    assign flush_out          = apply && eff_valid;
    assign misaligned_out     = misaligned;
    assign state_out          = state;

endmodule

// File: tb/tb_msrv32_pc_seq_ctrl.sv
// Directed bench: expected fetch addresses go into a queue that a negedge
// monitor drains on every completed handshake; side outputs checked inline.
module tb_msrv32_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, trap = 1'b0, mret = 1'b0;
    logic [31:0] branch_tgt = '0, trap_vec = '0, epc = '0;
    logic [31:0] pc, pc_mux;
    logic        pc_load, flush, misaligned;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    msrv32_pc_seq_ctrl_if imem_if();

    msrv32_pc_seq_ctrl #(.BOOT_ADDR(32'h0), .RESET_HOLD_CYC(2)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .stall_in             (stall),
        .branch_taken_in      (branch),
        .branch_target_in     (branch_tgt),
        .trap_taken_in        (trap),
        .trap_vector_in       (trap_vec),
        .mret_in              (mret),
        .epc_in               (epc),
        .imem                 (imem_if),
        .pc_out               (pc),
        .pc_mux_out           (pc_mux),
        .pc_load_out          (pc_load),
        .flush_out            (flush),
        .misaligned_out       (misaligned),
        .state_out            (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed fetch handshake must match the next expected address.
    always @(negedge clk) begin
        if (rst_n && imem_if.imem_req_out && imem_if.imem_ready_in) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL fetch_unexpected: got %h want none", imem_if.imem_addr_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (imem_if.imem_addr_out !== e) begin
                    bad++;
                    $display("FAIL fetch_addr: got %h want %h", imem_if.imem_addr_out, e);
                end
            end
        end
    end

    initial begin
        imem_if.imem_ready_in = 1'b1;
        step(); #1;
        chk("rst_req", 32'(imem_if.imem_req_out), 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", 32'(state), 0);
        chk("rst_mux", pc_mux, 32'h0);
        chk("rst_load_flush", {30'h0, pc_load, flush}, 0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        rst_n = 1'b1; #1;
        chk("hold0_req", 32'(imem_if.imem_req_out), 0);
        // C1: still holding
        step(); #1;
        chk("hold1_req", 32'(imem_if.imem_req_out), 0);
        chk("hold1_state", 32'(state), 0);
        // C2: first fetch at 0
        step(); #1;
        chk("fetch0", {imem_if.imem_req_out, imem_if.imem_addr_out[30:0]}, 32'h8000_0000);
        // C3..C5: wait-states at 0x4
        for (int i = 0; i < 3; i++) begin
            step(); imem_if.imem_ready_in = 1'b0; #1;
            chk("wait4", {imem_if.imem_req_out, imem_if.imem_addr_out[30:0]}, 32'h8000_0004);
        end
        // C6: ack at 0x4
        step(); exp_q.push_back(32'h8); imem_if.imem_ready_in = 1'b1; #1;
        chk("ack4_addr", imem_if.imem_addr_out, 32'h4);
        // C7: fetch 0x8, stretched
        step(); imem_if.imem_ready_in = 1'b0; #1;
        chk("pc8", pc, 32'h8);
        // C8: branch during WAIT
        step(); branch = 1'b1; branch_tgt = 32'h130; #1;
        chk("wait_state", 32'(state), 2);
        // C9: ack applies pending branch
        step(); branch = 1'b0; imem_if.imem_ready_in = 1'b1; #1;
        chk("br_flush", 32'(flush), 1);
        chk("br_mux", pc_mux, 32'h130);
        chk("br_load", 32'(pc_load), 1);
        // C10
        step(); exp_q.push_back(32'h130); #1;
        chk("br_pc", pc, 32'h130);
        chk("br_flush_end", 32'(flush), 0);
        // C11: trap beats branch in the ack cycle
        step(); exp_q.push_back(32'h134);
        trap = 1'b1; trap_vec = 32'h100; branch = 1'b1; branch_tgt = 32'h200; #1;
        chk("trap_mux", pc_mux, 32'h100);
        chk("trap_flush", 32'(flush), 1);
        // C12: mret, epc low bits forced to zero
        step(); trap = 1'b0; branch = 1'b0; exp_q.push_back(32'h100);
        mret = 1'b1; epc = 32'h47; #1;
        chk("trap_pc", pc, 32'h100);
        chk("mret_mux", pc_mux, 32'h44);
        chk("mret_flush", 32'(flush), 1);
        // C13: misaligned branch is rejected
        step(); mret = 1'b0; exp_q.push_back(32'h44);
        branch = 1'b1; branch_tgt = 32'h13; #1;
        chk("mret_pc", pc, 32'h44);
        chk("mis_pulse", 32'(misaligned), 1);
        chk("mis_noflush", 32'(flush), 0);
        chk("mis_mux", pc_mux, 32'h48);
        // C14
        step(); branch = 1'b0; exp_q.push_back(32'h48); #1;
        chk("mis_end", 32'(misaligned), 0);
        chk("mis_pc", pc, 32'h48);
        // C15: stall in FETCH
        step(); stall = 1'b1; #1;
        chk("stall_req", 32'(imem_if.imem_req_out), 0);
        chk("stall_load", 32'(pc_load), 0);
        // C16: trap while stalled
        step(); trap = 1'b1; trap_vec = 32'h82; #1;
        chk("stall_state", 32'(state), 3);
        chk("stall_pc", pc, 32'h4C);
        chk("stall_trap_flush", 32'(flush), 1);
        chk("stall_trap_mux", pc_mux, 32'h80);
        // C17: redirect landed, still STALL; release stall
        step(); trap = 1'b0; stall = 1'b0; #1;
        chk("stall_trap_pc", pc, 32'h80);
        chk("stall_state2", 32'(state), 3);
        chk("stall_flush_end", 32'(flush), 0);
        // C18: fetch 0x80, branch to top of memory
        step(); exp_q.push_back(32'h80); branch = 1'b1; branch_tgt = 32'hFFFF_FFFC; #1;
        chk("resume_addr", imem_if.imem_addr_out, 32'h80);
        chk("top_flush", 32'(flush), 1);
        // C19: wrap-around of +4
        step(); branch = 1'b0; exp_q.push_back(32'hFFFF_FFFC); #1;
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_mux", pc_mux, 32'h0);
        // C20
        step(); exp_q.push_back(32'h0); #1;
        chk("wrap_pc", pc, 32'h0);
        // C21: go into WAIT at 0x4
        step(); imem_if.imem_ready_in = 1'b0; #1;
        chk("pre_rst_pc", pc, 32'h4);
        // C22: reset asserted in WAIT
        step(); #1;
        chk("pre_rst_state", 32'(state), 2);
        chk("pre_rst_req", {imem_if.imem_req_out, imem_if.imem_addr_out[30:0]}, 32'h8000_0004);
        rst_n = 1'b0; #1;
        chk("rst_wait_req", 32'(imem_if.imem_req_out), 0);
        chk("rst_wait_pc", pc, 32'h0);
        chk("rst_wait_state", 32'(state), 0);
        step(); step();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
